// File: rtl/led_pkg.sv
// led_pkg: state encoding and default timing constants shared by the
// one-wire LED bit encoder, its producers and its testbenches.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } led_state_e;

  // Default WS2812-style timing, in clk cycles.
  localparam int LED_T0H_CYCLES   = 20;
  localparam int LED_T1H_CYCLES   = 40;
  localparam int LED_BIT_CYCLES   = 63;
  localparam int LED_LATCH_CYCLES = 14000;

  // Counter width able to hold the longest interval the encoder times.
  function automatic int led_cnt_width(input int bit_cycles, input int latch_cycles);
    int longest;
    longest = (bit_cycles > latch_cycles) ? bit_cycles : latch_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// led_bit_encoder: pops single bits from a first-word-fall-through FIFO and
// emits them as NRZ one-wire pulses (WS2812-style). Bits go back to back
// with no gap; when the FIFO runs dry the line is held low for a latch
// interval and o_frame_done pulses on its final cycle.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_data        FIFO head bit, valid while i_empty is low
//   i_empty       FIFO empty flag
//   o_read        FIFO pop strobe (combinational), head consumed on that edge
//   o_led         registered serial LED data line
//   o_busy        high whenever the encoder is not IDLE
//   o_frame_done  one-cycle pulse on the last latch cycle
//
// Build option:
//   LED_ENC_INVERT_OUT_EN  when defined, o_led is inverted (idle/reset level 1)
//                          for strips behind an inverting level shifter.
//
// state | meaning
// IDLE  | line idle, waiting for the FIFO to become non-empty
// HIGH  | driving the high part of the current bit (T0H or T1H cycles)
// LOW   | driving the low remainder of the bit period
// LATCH | line held low so the strip latches the frame
module led_bit_encoder
  import led_pkg::*;
#(
  parameter int T0H_CYCLES   = LED_T0H_CYCLES,
  parameter int T1H_CYCLES   = LED_T1H_CYCLES,
  parameter int BIT_CYCLES   = LED_BIT_CYCLES,
  parameter int LATCH_CYCLES = LED_LATCH_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_data,
  input  logic i_empty,
  output logic o_read,
  output logic o_led,
  output logic o_busy,
  output logic o_frame_done
);

  localparam int CW = led_cnt_width(BIT_CYCLES, LATCH_CYCLES);

  localparam logic [CW-1:0] T0H_LAST  = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_LAST  = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] T0L_LAST  = CW'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1L_LAST  = CW'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST  = CW'(LATCH_CYCLES - 1);
  // Cycle before the last latch cycle; o_frame_done is registered, so it is
  // armed one cycle early. Unused (never reached) when LATCH_CYCLES == 1.
  localparam logic [CW-1:0] LAT_PRE   = CW'(LATCH_CYCLES - 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef LED_ENC_INVERT_OUT_EN
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;
`endif

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
        T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES > 0)) begin : g_bad_params
    $error("led_bit_encoder: need 0 < T0H < T1H < BIT and LATCH > 0");
  end

  led_state_e    state;
  logic [CW-1:0] counter;
  logic          bit_q;

  logic [CW-1:0] high_last;
  logic [CW-1:0] low_last;
  logic          pop_slot;

  assign high_last = bit_q ? T1H_LAST : T0H_LAST;
  assign low_last  = bit_q ? T1L_LAST : T0L_LAST;

  // A pop is allowed in IDLE and on the final LOW cycle of a bit, which is
  // what keeps back-to-back bits exactly BIT_CYCLES apart.
  assign pop_slot = (state == IDLE) || (state == LOW && counter == low_last);
  assign o_read   = pop_slot && !i_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      counter      <= '0;
      bit_q        <= 1'b0;
      o_led        <= LED_OFF;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (o_read) begin
            bit_q   <= i_data;
            state   <= HIGH;
            counter <= '0;
            o_led   <= LED_ON;
            o_busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (counter == high_last) begin
            state   <= LOW;
            counter <= '0;
            o_led   <= LED_OFF;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        LOW: begin
          if (counter == low_last) begin
            counter <= '0;
            if (o_read) begin
              bit_q <= i_data;
              state <= HIGH;
              o_led <= LED_ON;
            end else begin
              state        <= LATCH;
              o_frame_done <= (LATCH_CYCLES == 1);
            end
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        LATCH: begin
          if (counter == LAT_LAST) begin
            state   <= IDLE;
            counter <= '0;
            o_busy  <= 1'b0;
          end else begin
            counter      <= counter + CNT_ONE;
            o_frame_done <= (counter == LAT_PRE);
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          o_led   <= LED_OFF;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bit_encoder.sv
// tb_led_bit_encoder: drives led_bit_encoder from a bench-side bit queue and
// compares every cycle against an event-level reference: each pop schedules
// its high pulse and busy window, each dry decision point schedules the
// latch interval and frame-done pulse.
module tb_led_bit_encoder;

  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int BITC  = 6;
  localparam int LATCH = 10;
  localparam int MAXC  = 8192;

`ifdef LED_ENC_INVERT_OUT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic empty = 1'b1;
  logic read;
  logic led;
  logic busy;
  logic done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit q[$];
  bit e_read[MAXC];
  bit e_led[MAXC];
  bit e_busy[MAXC];
  bit e_done[MAXC];

  bit in_frame = 1'b0;
  int decision = 0;
  int idle_from = 0;

  led_bit_encoder #(
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .BIT_CYCLES  (BITC),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_data      (din),
    .i_empty     (empty),
    .o_read      (read),
    .o_led       (led),
    .o_busy      (busy),
    .o_frame_done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    empty = (q.size() == 0);
    din   = (q.size() != 0) ? q[0] : 1'b0;
  endtask

  // One clock cycle: evaluate the reference at the negedge, compare, then
  // advance past the next rising edge.
  task automatic step();
    bit popped;
    int w;
    popped = 1'b0;
    drive_fifo();
    @(negedge clk);
    if (cyc > MAXC - 64) begin
      failures++;
      $display("FAIL cycle_budget cycle=%0d got=over want=under_%0d", cyc, MAXC - 64);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "cycle budget exhausted");
    end
    if (!rst) begin
      if (!empty && ((!in_frame && cyc >= idle_from) || (in_frame && cyc == decision))) begin
        popped = 1'b1;
        e_read[cyc] = 1'b1;
        w = q[0] ? T1H : T0H;
        for (int k = 1; k <= w; k++) e_led[cyc + k] = 1'b1;
        for (int k = 1; k <= BITC; k++) e_busy[cyc + k] = 1'b1;
        in_frame = 1'b1;
        decision = cyc + BITC;
      end else if (in_frame && cyc == decision) begin
        for (int k = 1; k <= LATCH; k++) e_busy[cyc + k] = 1'b1;
        e_done[cyc + LATCH] = 1'b1;
        in_frame  = 1'b0;
        idle_from = cyc + LATCH + 1;
      end
    end
    check_val("o_read", read, e_read[cyc]);
    check_val("o_led", led, e_led[cyc] ^ INV);
    check_val("o_busy", busy, e_busy[cyc]);
    check_val("o_frame_done", done, e_done[cyc]);
    if (popped) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = cyc; i < MAXC; i++) begin
      e_read[i] = 1'b0;
      e_led[i]  = 1'b0;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
    end
    in_frame  = 1'b0;
    idle_from = 0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    // Reset, then idle with the FIFO empty.
    apply_reset(5);
    run(50);

    // Preloaded 1,0,1 then empty.
    q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    run(3 * BITC + LATCH + 10);

    // Underrun: two bits, the third lands during the latch.
    q.push_back(1'b0);
    q.push_back(1'b1);
    run(20);
    q.push_back(1'b1);
    run(BITC + LATCH + 10);

    // Data arriving at latch cycle 3.
    q.push_back(1'b0);
    run(BITC + 3);
    q.push_back(1'b1);
    run(BITC + LATCH + 10);

    // Reset during the HIGH phase of a 1 bit.
    q.push_back(1'b1);
    run(2);
    apply_reset(3);
    run(20);
    q.push_back(1'b0);
    run(BITC + LATCH + 5);

    // Randomized bursts with random gaps.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 5);
      repeat (n) q.push_back(1'($urandom_range(0, 1)));
      run($urandom_range(0, 40));
    end
    run(BITC * (q.size() + 2) + LATCH + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
